aska_pulse_monitor: RTL and testbench

ASKA_PULSE_MONITOR -- requirements
Module: aska_pulse_monitor

---
 rtl/aska_pulse_monitor.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_aska_pulse_monitor.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aska_pulse_monitor.sv
// aska_pulse_monitor: watches the H-bridge switch controls and DAC code, measures
// each biphasic pulse (phase lengths, gap, charge, period) and flags malformed pulses.
module aska_pulse_monitor (
   input  logic        clk,
   input  logic        resetn,
   input  logic        enable,
   input  logic [2:0]  up_switches,
   input  logic [2:0]  down_switches,
   input  logic [5:0]  DAC,
   input  logic [3:0]  phase_limit,
   input  logic        clear_faults,
   output logic        pulse_valid,
   output logic [3:0]  pos_len,
   output logic [3:0]  neg_len,
   output logic [3:0]  gap_len,
   output logic [9:0]  pos_charge,
   output logic [9:0]  neg_charge,
   output logic [12:0] last_period,
   output logic        period_valid,
   output logic [15:0] pulse_count,
   output logic        fault_short,
   output logic        fault_polarity,
   output logic        fault_missing_neg,
   output logic        fault_imbalance,
   output logic        fault_overlong,
   output logic        any_fault
);

   localparam int unsigned SW_W  = 3;
   localparam int unsigned DAC_W = 6;
   localparam int unsigned LEN_W = 4;
   localparam int unsigned CHG_W = 10;
   localparam int unsigned SUM_W = CHG_W + 1;
   localparam int unsigned PER_W = 13;
   localparam int unsigned CNT_W = 16;
   localparam int unsigned NFLT  = 5;

   // Bit positions inside the sticky fault vector
   localparam int unsigned F_SHORT = 0;
   localparam int unsigned F_POL   = 1;
   localparam int unsigned F_MISS  = 2;
   localparam int unsigned F_IMB   = 3;
   localparam int unsigned F_OVER  = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_POS  = 2'd1,
      ST_GAP  = 2'd2,
      ST_NEG  = 2'd3
   } state_t;

   state_t state_q;
   state_t state_d;

   // Captured switch patterns of the first phase
   logic [SW_W-1:0]  p_q;
   logic [SW_W-1:0]  n_q;

   // In-flight measurement
   logic [LEN_W-1:0] pos_len_cnt;
   logic [LEN_W-1:0] neg_len_cnt;
   logic [LEN_W-1:0] gap_cnt;
   logic [CHG_W-1:0] pos_acc;
   logic [CHG_W-1:0] neg_acc;

   // Period tracking
   logic [PER_W-1:0] period_cnt;
   logic             period_seen;

   // Sticky faults
   logic [NFLT-1:0]  fault_q;
   logic [NFLT-1:0]  fault_set_c;
   logic [NFLT-1:0]  fault_d_c;

   // Decoded input patterns
   logic active_c;
   logic idle_pat_c;
   logic match_pn_c;
   logic match_np_c;

   // FSM control strobes
   logic start_c;
   logic pos_step_c;
   logic pos_to_gap_c;
   logic enter_neg_c;
   logic gap_clr_c;
   logic gap_step_c;
   logic neg_step_c;
   logic publish_c;
   logic set_polarity_c;
   logic set_missing_c;

   // Saturating phase-length increment
   function automatic logic [LEN_W-1:0] len_inc(input logic [LEN_W-1:0] v);
      return (v == '1) ? v : v + LEN_W'(1);
   endfunction

   // Saturating charge accumulation
   function automatic logic [CHG_W-1:0] acc_add(input logic [CHG_W-1:0] acc,
                                                input logic [DAC_W-1:0] dac);
      logic [SUM_W-1:0] sum;
      sum = SUM_W'(acc) + SUM_W'(dac);
      return sum[CHG_W] ? '1 : sum[CHG_W-1:0];
   endfunction

   // Pattern decode against the captured first-phase polarity
   always_comb begin
      active_c   = |up_switches;
      idle_pat_c = (up_switches == '0) && (down_switches == '0);
      match_pn_c = (up_switches == p_q) && (down_switches == n_q);
      match_np_c = (up_switches == n_q) && (down_switches == p_q);
   end

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // Next-state and control strobes; pattern priority is (P,N), idle, (N,P)
   always_comb begin
      state_d        = state_q;
      start_c        = 1'b0;
      pos_step_c     = 1'b0;
      pos_to_gap_c   = 1'b0;
      enter_neg_c    = 1'b0;
      gap_clr_c      = 1'b0;
      gap_step_c     = 1'b0;
      neg_step_c     = 1'b0;
      publish_c      = 1'b0;
      set_polarity_c = 1'b0;
      set_missing_c  = 1'b0;
      if (!enable) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (active_c) begin
                  start_c = 1'b1;
                  state_d = ST_POS;
               end
            end
            ST_POS: begin
               if (match_pn_c) begin
                  pos_step_c = 1'b1;
               end else if (idle_pat_c) begin
                  pos_to_gap_c = 1'b1;
                  state_d      = ST_GAP;
               end else if (match_np_c) begin
                  enter_neg_c = 1'b1;
                  gap_clr_c   = 1'b1;
                  state_d     = ST_NEG;
               end else begin
                  set_polarity_c = 1'b1;
                  state_d        = ST_IDLE;
               end
            end
            ST_GAP: begin
               if (idle_pat_c) begin
                  if (gap_cnt == '1) begin
                     set_missing_c = 1'b1;
                     state_d       = ST_IDLE;
                  end else begin
                     gap_step_c = 1'b1;
                  end
               end else if (match_np_c) begin
                  enter_neg_c = 1'b1;
                  state_d     = ST_NEG;
               end else begin
                  set_polarity_c = 1'b1;
                  state_d        = ST_IDLE;
               end
            end
            ST_NEG: begin
               if (match_np_c) begin
                  neg_step_c = 1'b1;
               end else if (idle_pat_c) begin
                  publish_c = 1'b1;
                  state_d   = ST_IDLE;
               end else begin
                  set_polarity_c = 1'b1;
                  state_d        = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // In-flight pulse measurement: polarity capture, lengths, gap and charge
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         p_q         <= '0;
         n_q         <= '0;
         pos_len_cnt <= '0;
         neg_len_cnt <= '0;
         gap_cnt     <= '0;
         pos_acc     <= '0;
         neg_acc     <= '0;
      end else begin
         if (start_c) begin
            p_q         <= up_switches;
            n_q         <= down_switches;
            pos_len_cnt <= LEN_W'(1);
            pos_acc     <= CHG_W'(DAC);
         end else if (pos_step_c) begin
            pos_len_cnt <= len_inc(pos_len_cnt);
            pos_acc     <= acc_add(pos_acc, DAC);
         end
         if (pos_to_gap_c)    gap_cnt <= LEN_W'(1);
         else if (gap_clr_c)  gap_cnt <= '0;
         else if (gap_step_c) gap_cnt <= gap_cnt + LEN_W'(1);
         if (enter_neg_c) begin
            neg_len_cnt <= LEN_W'(1);
            neg_acc     <= CHG_W'(DAC);
         end else if (neg_step_c) begin
            neg_len_cnt <= len_inc(neg_len_cnt);
            neg_acc     <= acc_add(neg_acc, DAC);
         end
      end
   end

   // Published measurement, one-cycle strobe and wrapping pulse counter
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pulse_valid <= 1'b0;
         pos_len     <= '0;
         neg_len     <= '0;
         gap_len     <= '0;
         pos_charge  <= '0;
         neg_charge  <= '0;
         pulse_count <= '0;
      end else begin
         pulse_valid <= publish_c;
         if (publish_c) begin
            pos_len     <= pos_len_cnt;
            neg_len     <= neg_len_cnt;
            gap_len     <= gap_cnt;
            pos_charge  <= pos_acc;
            neg_charge  <= neg_acc;
            pulse_count <= pulse_count + CNT_W'(1);
         end
      end
   end

   // Start-to-start period measurement; disabling forgets the previous start
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         period_cnt   <= '0;
         period_seen  <= 1'b0;
         last_period  <= '0;
         period_valid <= 1'b0;
      end else begin
         if (start_c)                 period_cnt <= PER_W'(1);
         else if (period_cnt != '1)   period_cnt <= period_cnt + PER_W'(1);
         if (!enable)      period_seen <= 1'b0;
         else if (start_c) period_seen <= 1'b1;
         if (start_c && period_seen) begin
            last_period  <= period_cnt;
            period_valid <= 1'b1;
         end
      end
   end

   // Fault set conditions; a set in the same cycle as a clear wins
   always_comb begin
      fault_set_c          = '0;
      fault_set_c[F_SHORT] = enable && ((up_switches & down_switches) != '0);
      fault_set_c[F_POL]   = set_polarity_c;
      fault_set_c[F_MISS]  = set_missing_c;
      fault_set_c[F_IMB]   = publish_c &&
                             ((pos_acc != neg_acc) || (pos_len_cnt != neg_len_cnt));
      fault_set_c[F_OVER]  = publish_c &&
                             ((pos_len_cnt > phase_limit) || (neg_len_cnt > phase_limit));
      fault_d_c            = fault_set_c | (fault_q & ~{NFLT{clear_faults}});
   end

   // Sticky fault register and its summary flag
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         fault_q   <= '0;
         any_fault <= 1'b0;
      end else begin
         fault_q   <= fault_d_c;
         any_fault <= |fault_d_c;
      end
   end

   assign fault_short       = fault_q[F_SHORT];
   assign fault_polarity    = fault_q[F_POL];
   assign fault_missing_neg = fault_q[F_MISS];
   assign fault_imbalance   = fault_q[F_IMB];
   assign fault_overlong    = fault_q[F_OVER];

endmodule

// File: tb/tb_aska_pulse_monitor.sv
// tb_aska_pulse_monitor: table-driven pulses with a scoreboard of expected publishes,
// plus hand-written sequences for period, abort, missing-phase and fault corners.
`timescale 1ns/1ps
module tb_aska_pulse_monitor;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        enable = 1'b0;
   logic [2:0]  up_switches = '0;
   logic [2:0]  down_switches = '0;
   logic [5:0]  DAC = '0;
   logic [3:0]  phase_limit = 4'd15;
   logic        clear_faults = 1'b0;
   logic        pulse_valid;
   logic [3:0]  pos_len, neg_len, gap_len;
   logic [9:0]  pos_charge, neg_charge;
   logic [12:0] last_period;
   logic        period_valid;
   logic [15:0] pulse_count;
   logic        fault_short, fault_polarity, fault_missing_neg;
   logic        fault_imbalance, fault_overlong, any_fault;

   aska_pulse_monitor dut (
      .clk(clk), .resetn(resetn), .enable(enable),
      .up_switches(up_switches), .down_switches(down_switches),
      .DAC(DAC), .phase_limit(phase_limit), .clear_faults(clear_faults),
      .pulse_valid(pulse_valid), .pos_len(pos_len), .neg_len(neg_len),
      .gap_len(gap_len), .pos_charge(pos_charge), .neg_charge(neg_charge),
      .last_period(last_period), .period_valid(period_valid),
      .pulse_count(pulse_count), .fault_short(fault_short),
      .fault_polarity(fault_polarity), .fault_missing_neg(fault_missing_neg),
      .fault_imbalance(fault_imbalance), .fault_overlong(fault_overlong),
      .any_fault(any_fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] pos_len;
      logic [3:0] neg_len;
      logic [3:0] gap_len;
      logic [9:0] pos_ch;
      logic [9:0] neg_ch;
   } pub_t;

   typedef struct {
      logic [2:0] up;
      logic [2:0] dn;
      logic [5:0] a1;
      int         l1;
      int         gap;
      logic [5:0] a2;
      int         l2;
      logic [3:0] lim;
      pub_t       e;
      logic       imb;
      logic       over;
   } vec_t;

   pub_t        sb_q[$];
   vec_t        tbl[5];
   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned exp_count = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic pub_t mk_pub(input logic [3:0] pl, input logic [3:0] nl,
                                   input logic [3:0] gl, input logic [9:0] pc,
                                   input logic [9:0] nc);
      pub_t p;
      p.pos_len = pl; p.neg_len = nl; p.gap_len = gl; p.pos_ch = pc; p.neg_ch = nc;
      return p;
   endfunction

   function automatic vec_t mk_vec(input logic [2:0] up, input logic [2:0] dn,
                                   input logic [5:0] a1, input int l1, input int gap,
                                   input logic [5:0] a2, input int l2, input logic [3:0] lim,
                                   input pub_t e, input logic imb, input logic over);
      vec_t v;
      v.up = up; v.dn = dn; v.a1 = a1; v.l1 = l1; v.gap = gap; v.a2 = a2; v.l2 = l2;
      v.lim = lim; v.e = e; v.imb = imb; v.over = over;
      return v;
   endfunction

   // Scoreboard: every strobe must match the oldest expected publish
   always @(negedge clk) begin
      if (resetn && pulse_valid) begin
         pub_t e;
         if (sb_q.size() == 0) begin
            chk("unexpected_pulse_valid", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            chk("pos_len", 32'(pos_len), 32'(e.pos_len));
            chk("neg_len", 32'(neg_len), 32'(e.neg_len));
            chk("gap_len", 32'(gap_len), 32'(e.gap_len));
            chk("pos_charge", 32'(pos_charge), 32'(e.pos_ch));
            chk("neg_charge", 32'(neg_charge), 32'(e.neg_ch));
         end
      end
   end

   task automatic cyc(input logic [2:0] u, input logic [2:0] d, input logic [5:0] a,
                      input logic clr = 1'b0);
      up_switches = u; down_switches = d; DAC = a; clear_faults = clr;
      @(posedge clk); #1;
   endtask

   // Full biphasic pulse ending on the publishing idle edge
   task automatic pulse(input logic [2:0] u, input logic [2:0] d, input logic [5:0] a1,
                        input int l1, input int gap, input logic [5:0] a2, input int l2,
                        input pub_t e, input logic clr_at_start);
      for (int i = 0; i < l1; i++) cyc(u, d, a1, (i == 0) ? clr_at_start : 1'b0);
      for (int i = 0; i < gap; i++) cyc(3'b000, 3'b000, 6'd0);
      for (int i = 0; i < l2; i++) cyc(d, u, a2);
      sb_q.push_back(e);
      cyc(3'b000, 3'b000, 6'd0);
      exp_count++;
      chk("pulse_valid", 32'(pulse_valid), 32'd1);
      chk("pulse_count", 32'(pulse_count), exp_count);
   endtask

   initial begin
      pub_t base;
      base = mk_pub(4'd4, 4'd4, 4'd1, 10'd80, 10'd80);
      tbl[0] = mk_vec(3'b001, 3'b010, 6'd20, 4, 1, 6'd20, 4, 4'd15, base, 1'b0, 1'b0);
      tbl[1] = mk_vec(3'b001, 3'b010, 6'd20, 4, 1, 6'd10, 4, 4'd3,
                      mk_pub(4'd4, 4'd4, 4'd1, 10'd80, 10'd40), 1'b1, 1'b1);
      tbl[2] = mk_vec(3'b100, 3'b001, 6'd5, 3, 0, 6'd5, 3, 4'd3,
                      mk_pub(4'd3, 4'd3, 4'd0, 10'd15, 10'd15), 1'b0, 1'b0);
      tbl[3] = mk_vec(3'b010, 3'b100, 6'd63, 17, 2, 6'd63, 17, 4'd15,
                      mk_pub(4'd15, 4'd15, 4'd2, 10'd1023, 10'd1023), 1'b0, 1'b0);
      tbl[4] = mk_vec(3'b001, 3'b100, 6'd10, 2, 15, 6'd10, 3, 4'd15,
                      mk_pub(4'd2, 4'd3, 4'd15, 10'd20, 10'd30), 1'b1, 1'b0);

      // Reset state
      enable = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pulse_valid", 32'(pulse_valid), 32'd0);
      chk("rst_pulse_count", 32'(pulse_count), 32'd0);
      chk("rst_last_period", 32'(last_period), 32'd0);
      chk("rst_period_valid", 32'(period_valid), 32'd0);
      chk("rst_pos_charge", 32'(pos_charge), 32'd0);
      chk("rst_any_fault", 32'(any_fault), 32'd0);
      resetn = 1'b1;
      cyc(3'b000, 3'b000, 6'd0);

      // Basic pulse, then a second start 401 cycles after the first
      pulse(3'b001, 3'b010, 6'd20, 4, 1, 6'd20, 4, base, 1'b0);
      chk("first_period_valid", 32'(period_valid), 32'd0);
      chk("first_any_fault", 32'(any_fault), 32'd0);
      repeat (391) cyc(3'b000, 3'b000, 6'd0);
      pulse(3'b001, 3'b010, 6'd20, 4, 1, 6'd20, 4, base, 1'b0);
      chk("last_period_401", 32'(last_period), 32'd401);
      chk("period_valid_set", 32'(period_valid), 32'd1);

      // Abort mid-POS by enable: start lands 10 cycles after the previous one
      cyc(3'b001, 3'b010, 6'd20);
      cyc(3'b001, 3'b010, 6'd20);
      enable = 1'b0;
      cyc(3'b001, 3'b010, 6'd20);
      enable = 1'b1;
      cyc(3'b000, 3'b000, 6'd0);
      cyc(3'b000, 3'b000, 6'd0);
      chk("abort_count_hold", 32'(pulse_count), exp_count);
      pulse(3'b001, 3'b010, 6'd20, 4, 1, 6'd20, 4, base, 1'b0);
      chk("abort_last_period", 32'(last_period), 32'd10);
      chk("abort_period_valid", 32'(period_valid), 32'd1);
      chk("abort_any_fault", 32'(any_fault), 32'd0);

      // Table of pulses, back to back, faults cleared on each start edge
      for (int i = 0; i < 5; i++) begin
         phase_limit = tbl[i].lim;
         pulse(tbl[i].up, tbl[i].dn, tbl[i].a1, tbl[i].l1, tbl[i].gap,
               tbl[i].a2, tbl[i].l2, tbl[i].e, 1'b1);
         chk($sformatf("tbl%0d_imbalance", i), 32'(fault_imbalance), 32'(tbl[i].imb));
         chk($sformatf("tbl%0d_overlong", i), 32'(fault_overlong), 32'(tbl[i].over));
         chk($sformatf("tbl%0d_any_fault", i), 32'(any_fault), 32'(tbl[i].imb | tbl[i].over));
         chk($sformatf("tbl%0d_polarity", i), 32'(fault_polarity), 32'd0);
      end
      phase_limit = 4'd15;

      // Missing second phase: fault on the 16th idle cycle, not the 15th
      cyc(3'b001, 3'b010, 6'd20, 1'b1);
      cyc(3'b001, 3'b010, 6'd20);
      cyc(3'b001, 3'b010, 6'd20);
      repeat (15) cyc(3'b000, 3'b000, 6'd0);
      chk("missing_at_15", 32'(fault_missing_neg), 32'd0);
      cyc(3'b000, 3'b000, 6'd0);
      chk("missing_at_16", 32'(fault_missing_neg), 32'd1);
      chk("missing_any", 32'(any_fault), 32'd1);
      cyc(3'b000, 3'b000, 6'd0, 1'b1);
      chk("missing_cleared", 32'(fault_missing_neg), 32'd0);
      chk("missing_any_cleared", 32'(any_fault), 32'd0);
      chk("missing_count_hold", 32'(pulse_count), exp_count);

      // Short and polarity
      cyc(3'b011, 3'b010, 6'd20);
      chk("short_set", 32'(fault_short), 32'd1);
      chk("short_no_polarity", 32'(fault_polarity), 32'd0);
      cyc(3'b100, 3'b001, 6'd20);
      chk("polarity_set", 32'(fault_polarity), 32'd1);
      repeat (3) cyc(3'b000, 3'b000, 6'd0);
      chk("polarity_count_hold", 32'(pulse_count), exp_count);
      cyc(3'b000, 3'b000, 6'd0, 1'b1);
      chk("short_cleared", 32'(fault_short), 32'd0);
      // Set and clear in the same cycle: set wins
      cyc(3'b001, 3'b001, 6'd5, 1'b1);
      chk("set_wins", 32'(fault_short), 32'd1);
      cyc(3'b010, 3'b000, 6'd5);
      chk("polarity_again", 32'(fault_polarity), 32'd1);
      cyc(3'b000, 3'b000, 6'd0, 1'b1);
      chk("all_cleared", 32'(any_fault), 32'd0);

      // Reset mid-POS, then a clean pulse
      cyc(3'b001, 3'b010, 6'd20);
      cyc(3'b001, 3'b010, 6'd20);
      resetn = 1'b0;
      #2;
      exp_count = 0;
      chk("midrst_count", 32'(pulse_count), 32'd0);
      chk("midrst_period_valid", 32'(period_valid), 32'd0);
      chk("midrst_last_period", 32'(last_period), 32'd0);
      chk("midrst_pos_len", 32'(pos_len), 32'd0);
      @(posedge clk); #1;
      resetn = 1'b1;
      cyc(3'b000, 3'b000, 6'd0);
      pulse(3'b001, 3'b010, 6'd20, 4, 1, 6'd20, 4, base, 1'b0);
      chk("postrst_period_valid", 32'(period_valid), 32'd0);
      chk("postrst_any_fault", 32'(any_fault), 32'd0);

      repeat (3) cyc(3'b000, 3'b000, 6'd0);
      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
